// File: rtl/clock_div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clock_div_pkg                                                    |
// | Shared constants and helpers for the programmable clock dividers |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package clock_div_pkg;

   localparam int unsigned CLK_HZ        = 50000000;
   localparam int unsigned DIV_W_DEFAULT = 25;
   localparam int unsigned DEFAULT_DIV   = 25000000;

   // Half-period divisor producing a clk_out of the requested frequency.
   function automatic int unsigned div_for_hz(input int unsigned hz);
      if (hz == 0) begin
         return 0;
      end
      return CLK_HZ / (2 * hz);
   endfunction

endpackage : clock_div_pkg
`default_nettype wire

// File: rtl/clock_div_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clock_div_channel                                                |
// | One divider channel: 50% duty clk_out, tick strobe, shadow reload|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module clock_div_channel
   import clock_div_pkg::*;
#(
   parameter int          DIV_W       = DIV_W_DEFAULT,
   parameter int unsigned RESET_DIV   = DEFAULT_DIV
) (
   input  logic             input_clk,
   input  logic             rst_n,
   input  logic             sync,
   input  logic             en,
   input  logic             ld,
   input  logic [DIV_W-1:0] ld_div,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [DIV_W-1:0] c_RESET_DIV = DIV_W'(RESET_DIV);

   logic [DIV_W-1:0] r_counter;
   logic [DIV_W-1:0] r_active_div;
   logic [DIV_W-1:0] r_shadow_div;
   logic             r_pending;
   logic             r_clk_out;
   logic             r_tick;

   logic             w_idle;
   logic             w_terminal;

   assign w_idle     = !en || (r_active_div == '0);
   assign w_terminal = (r_counter == (r_active_div - 1'b1));

   always_ff @(posedge input_clk) begin
      if (!rst_n) begin
         r_counter    <= '0;
         r_active_div <= c_RESET_DIV;
         r_shadow_div <= c_RESET_DIV;
         r_pending    <= 1'b0;
         r_clk_out    <= 1'b0;
         r_tick       <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (sync) begin
            r_counter <= '0;
            r_clk_out <= 1'b0;
            if (r_pending) begin
               r_active_div <= r_shadow_div;
               r_pending    <= 1'b0;
            end
         end else if (w_idle) begin
            if (r_pending) begin
               r_active_div <= r_shadow_div;
               r_pending    <= 1'b0;
            end
         end else if (w_terminal) begin
            // Reload only at a half-period boundary so no runt phase appears.
            r_counter <= '0;
            r_clk_out <= ~r_clk_out;
            r_tick    <= 1'b1;
            if (r_pending) begin
               r_active_div <= r_shadow_div;
               r_pending    <= 1'b0;
            end
         end else begin
            r_counter <= r_counter + 1'b1;
         end

         // A same-edge write stays pending; the reload above used the old shadow.
         if (ld) begin
            r_shadow_div <= ld_div;
            r_pending    <= 1'b1;
         end
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;

endmodule : clock_div_channel
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clock_divider_multi                                              |
// | N-channel programmable clock divider / tick generator            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module clock_divider_multi
   import clock_div_pkg::*;
#(
   parameter int          N_CH        = 4,
   parameter int          DIV_W       = 25,
   parameter int unsigned DEFAULT_DIV = clock_div_pkg::DEFAULT_DIV,
   localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             input_clk,
   input  logic             rst_n,
   input  logic             sync,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [DIV_W-1:0] wr_div,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick
);

   logic [N_CH-1:0] w_ld;

   // Out-of-range channel indices match no entry, so such writes drop out.
   always_comb begin
      w_ld = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_ld[i] = wr_en && (wr_ch == CH_W'(i));
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         clock_div_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DEFAULT_DIV)
         ) u_channel (
            .input_clk (input_clk),
            .rst_n     (rst_n),
            .sync      (sync),
            .en        (ch_en[gi]),
            .ld        (w_ld[gi]),
            .ld_div    (wr_div),
            .clk_out   (clk_out[gi]),
            .tick      (tick[gi])
         );
      end
   endgenerate

endmodule : clock_divider_multi
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_clock_divider_multi                                           |
// | Directed self-checking bench for clock_divider_multi             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_clock_divider_multi;

   logic       input_clk = 1'b0;
   logic       rst_n;
   logic       sync;
   logic [1:0] ch_en;
   logic       wr_en;
   logic       wr_ch;
   logic [7:0] wr_div;
   logic [1:0] clk_out;
   logic [1:0] tick;

   // Three-channel instance exists so an out-of-range wr_ch is expressible.
   logic [2:0] ch_en3 = 3'b111;
   logic       wr_en3;
   logic [1:0] wr_ch3;
   logic [2:0] clk_out3;
   logic [2:0] tick3;

   int n_checks = 0;
   int n_fail   = 0;

   clock_divider_multi #(.N_CH(2), .DIV_W(8), .DEFAULT_DIV(5)) dut (
      .input_clk (input_clk),
      .rst_n     (rst_n),
      .sync      (sync),
      .ch_en     (ch_en),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_div    (wr_div),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   clock_divider_multi #(.N_CH(3), .DIV_W(8), .DEFAULT_DIV(5)) dut3 (
      .input_clk (input_clk),
      .rst_n     (rst_n),
      .sync      (sync),
      .ch_en     (ch_en3),
      .wr_en     (wr_en3),
      .wr_ch     (wr_ch3),
      .wr_div    (wr_div),
      .clk_out   (clk_out3),
      .tick      (tick3)
   );

   always #5 input_clk = ~input_clk;

   task automatic step(input int n);
      repeat (n) @(posedge input_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic [1:0] exp_clk, input logic [1:0] exp_tick);
      chk({tag, ".clk"},  {1'b0, clk_out}, {1'b0, exp_clk});
      chk({tag, ".tick"}, {1'b0, tick},    {1'b0, exp_tick});
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      sync   = 1'b0;
      wr_en  = 1'b0;
      wr_en3 = 1'b0;
      ch_en  = 2'b11;
      step(2);
      rst_n  = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      sync   = 1'b0;
      ch_en  = 2'b11;
      wr_en  = 1'b0;
      wr_ch  = 1'b0;
      wr_div = 8'd0;
      wr_en3 = 1'b0;
      wr_ch3 = 2'd3;

      // Reset state and default D=5 cadence
      step(2);
      chk_main("rst", 2'b00, 2'b00);
      chk("rst3.clk", clk_out3, 3'b000);
      rst_n = 1'b1;
      step(4);  chk_main("t1_e4",  2'b00, 2'b00);
      step(1);  chk_main("t1_e5",  2'b11, 2'b11);
      step(1);  chk_main("t1_e6",  2'b11, 2'b00);
      step(3);  chk_main("t1_e9",  2'b11, 2'b00);
      step(1);  chk_main("t1_e10", 2'b00, 2'b11);

      // D=1 on ch0, then D=0 freezes it
      do_reset();
      wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd1;
      step(1);  wr_en = 1'b0;
      step(4);  chk_main("t2_e5",  2'b11, 2'b11);
      step(1);  chk_main("t2_e6",  2'b10, 2'b01);
      step(1);  chk_main("t2_e7",  2'b11, 2'b01);
      wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd0;
      step(1);  wr_en = 1'b0;
      step(2);  chk_main("t2_e10", 2'b01, 2'b10);
      step(3);  chk_main("t2_e13", 2'b01, 2'b00);

      // Mid-period write of 8 to ch1
      do_reset();
      step(7);
      wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd8;
      step(1);  wr_en = 1'b0;
      step(2);  chk_main("t3a_e10", 2'b00, 2'b11);
      step(7);  chk_main("t3a_e17", 2'b01, 2'b00);
      step(1);  chk_main("t3a_e18", 2'b11, 2'b10);

      // Write landing on the terminal-count edge
      do_reset();
      step(4);
      wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd8;
      step(1);  wr_en = 1'b0;
      chk_main("t3b_e5", 2'b11, 2'b11);
      step(5);  chk_main("t3b_e10", 2'b00, 2'b11);
      step(7);  chk_main("t3b_e17", 2'b01, 2'b00);
      step(1);  chk_main("t3b_e18", 2'b11, 2'b10);

      // ch0 D=3, ch1 D=7, sync pulse
      do_reset();
      wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd3;
      step(1);
      wr_ch = 1'b1; wr_div = 8'd7;
      step(1);  wr_en = 1'b0;
      step(4);  chk_main("t4_e6",  2'b11, 2'b00);
      sync = 1'b1;
      step(1);  chk_main("t4_sync", 2'b00, 2'b00);
      sync = 1'b0;
      step(2);  chk_main("t4_s2",  2'b00, 2'b00);
      step(1);  chk_main("t4_s3",  2'b01, 2'b01);
      step(3);  chk_main("t4_s6",  2'b00, 2'b01);
      step(1);  chk_main("t4_s7",  2'b10, 2'b10);

      // ch0 disabled for 4 cycles mid-count
      do_reset();
      step(7);
      ch_en = 2'b10;
      step(2);  chk_main("t5_e9",  2'b11, 2'b00);
      step(1);  chk_main("t5_e10", 2'b01, 2'b10);
      step(1);
      ch_en = 2'b11;
      step(2);  chk_main("t5_e13", 2'b01, 2'b00);
      step(1);  chk_main("t5_e14", 2'b00, 2'b01);

      // Out-of-range write ignored, then mid-period reset restores defaults
      do_reset();
      wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd1;
      wr_en3 = 1'b1; wr_ch3 = 2'd3;
      step(1);  wr_en = 1'b0; wr_en3 = 1'b0;
      step(3);  chk("t6_e4.clk3", clk_out3, 3'b000);
      step(1);  chk("t6_e5.clk3", clk_out3, 3'b111);
      chk("t6_e5.tick3", tick3, 3'b111);
      step(1);  chk_main("t6_e6", 2'b10, 2'b01);
      chk("t6_e6.tick3", tick3, 3'b000);
      step(1);  chk_main("t6_e7", 2'b11, 2'b01);
      rst_n = 1'b0;
      step(1);  chk_main("t6_rst", 2'b00, 2'b00);
      chk("t6_rst.clk3", clk_out3, 3'b000);
      rst_n = 1'b1;
      step(4);  chk_main("t6_r4", 2'b00, 2'b00);
      step(1);  chk_main("t6_r5", 2'b11, 2'b11);
      chk("t6_r5.clk3", clk_out3, 3'b111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_clock_divider_multi
`default_nettype wire
